// File: rtl/cgra_top.sv
// cgra_top: single-tile CGRA with one configurable 16-bit PE that reads a selected
// I/O side, combines it with a constant register and drives the S0 output pads.
module cgra_top #(
   parameter logic [2:0]  DEF_OP    = 3'd0,
   parameter logic [15:0] DEF_CONST = 16'd2,
   parameter logic [1:0]  DEF_SIDE  = 2'd2
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic [31:0] config_addr_in,
   input  logic [31:0] config_data_in,
   input  logic pad_S0_T0_in, pad_S0_T1_in, pad_S0_T2_in, pad_S0_T3_in,
   input  logic pad_S0_T4_in, pad_S0_T5_in, pad_S0_T6_in, pad_S0_T7_in,
   input  logic pad_S0_T8_in, pad_S0_T9_in, pad_S0_T10_in, pad_S0_T11_in,
   input  logic pad_S0_T12_in, pad_S0_T13_in, pad_S0_T14_in, pad_S0_T15_in,
   input  logic pad_S1_T0_in, pad_S1_T1_in, pad_S1_T2_in, pad_S1_T3_in,
   input  logic pad_S1_T4_in, pad_S1_T5_in, pad_S1_T6_in, pad_S1_T7_in,
   input  logic pad_S1_T8_in, pad_S1_T9_in, pad_S1_T10_in, pad_S1_T11_in,
   input  logic pad_S1_T12_in, pad_S1_T13_in, pad_S1_T14_in, pad_S1_T15_in,
   input  logic pad_S2_T0_in, pad_S2_T1_in, pad_S2_T2_in, pad_S2_T3_in,
   input  logic pad_S2_T4_in, pad_S2_T5_in, pad_S2_T6_in, pad_S2_T7_in,
   input  logic pad_S2_T8_in, pad_S2_T9_in, pad_S2_T10_in, pad_S2_T11_in,
   input  logic pad_S2_T12_in, pad_S2_T13_in, pad_S2_T14_in, pad_S2_T15_in,
   input  logic pad_S3_T0_in, pad_S3_T1_in, pad_S3_T2_in, pad_S3_T3_in,
   input  logic pad_S3_T4_in, pad_S3_T5_in, pad_S3_T6_in, pad_S3_T7_in,
   input  logic pad_S3_T8_in, pad_S3_T9_in, pad_S3_T10_in, pad_S3_T11_in,
   input  logic pad_S3_T12_in, pad_S3_T13_in, pad_S3_T14_in, pad_S3_T15_in,
   output logic pad_S0_T0_out, pad_S0_T1_out, pad_S0_T2_out, pad_S0_T3_out,
   output logic pad_S0_T4_out, pad_S0_T5_out, pad_S0_T6_out, pad_S0_T7_out,
   output logic pad_S0_T8_out, pad_S0_T9_out, pad_S0_T10_out, pad_S0_T11_out,
   output logic pad_S0_T12_out, pad_S0_T13_out, pad_S0_T14_out, pad_S0_T15_out,
   input  logic        tdi,
   input  logic        tms,
   input  logic        tck,
   input  logic        trst_n,
   output logic        tdo
);
   logic [15:0] side0, side1, side2, side3, a, result, out_bus;
   // Declaration values give correct power-on state without a reset pulse.
   logic [2:0]  op      = DEF_OP;
   logic [15:0] cnst    = DEF_CONST;
   logic [1:0]  side    = DEF_SIDE;
   logic        bypass  = 1'b0;
   logic [15:0] out_reg = 16'd0;
   logic        wr, unused_jtag;
   assign side0 = {pad_S0_T0_in, pad_S0_T1_in, pad_S0_T2_in, pad_S0_T3_in, pad_S0_T4_in, pad_S0_T5_in, pad_S0_T6_in, pad_S0_T7_in,
                   pad_S0_T8_in, pad_S0_T9_in, pad_S0_T10_in, pad_S0_T11_in, pad_S0_T12_in, pad_S0_T13_in, pad_S0_T14_in, pad_S0_T15_in};
   assign side1 = {pad_S1_T0_in, pad_S1_T1_in, pad_S1_T2_in, pad_S1_T3_in, pad_S1_T4_in, pad_S1_T5_in, pad_S1_T6_in, pad_S1_T7_in,
                   pad_S1_T8_in, pad_S1_T9_in, pad_S1_T10_in, pad_S1_T11_in, pad_S1_T12_in, pad_S1_T13_in, pad_S1_T14_in, pad_S1_T15_in};
   assign side2 = {pad_S2_T0_in, pad_S2_T1_in, pad_S2_T2_in, pad_S2_T3_in, pad_S2_T4_in, pad_S2_T5_in, pad_S2_T6_in, pad_S2_T7_in,
                   pad_S2_T8_in, pad_S2_T9_in, pad_S2_T10_in, pad_S2_T11_in, pad_S2_T12_in, pad_S2_T13_in, pad_S2_T14_in, pad_S2_T15_in};
   assign side3 = {pad_S3_T0_in, pad_S3_T1_in, pad_S3_T2_in, pad_S3_T3_in, pad_S3_T4_in, pad_S3_T5_in, pad_S3_T6_in, pad_S3_T7_in,
                   pad_S3_T8_in, pad_S3_T9_in, pad_S3_T10_in, pad_S3_T11_in, pad_S3_T12_in, pad_S3_T13_in, pad_S3_T14_in, pad_S3_T15_in};
   assign wr = config_addr_in[31:8] == 24'd0;
   always_comb begin
      a = side == 2'd0 ? side0 : side == 2'd1 ? side1 : side == 2'd2 ? side2 : side3;
      case (op)
         3'd0:    result = a * cnst;
         3'd1:    result = a + cnst;
         3'd2:    result = a - cnst;
         3'd3:    result = a & cnst;
         3'd4:    result = a | cnst;
         3'd5:    result = a ^ cnst;
         3'd6:    result = a << cnst[3:0];
         default: result = a;
      endcase
   end
   always_ff @(posedge clk_in or posedge reset_in)
      if (reset_in) begin
         op      <= DEF_OP;
         cnst    <= DEF_CONST;
         side    <= DEF_SIDE;
         bypass  <= 1'b0;
         out_reg <= 16'd0;
      end else begin
         if (wr && config_addr_in[7:0] == 8'h01) op <= config_data_in[2:0];
         if (wr && config_addr_in[7:0] == 8'h02) cnst <= config_data_in[15:0];
         if (wr && config_addr_in[7:0] == 8'h03) side <= config_data_in[1:0];
         if (wr && config_addr_in[7:0] == 8'h04) bypass <= config_data_in[0];
         out_reg <= result;
      end
   assign out_bus = bypass ? result : out_reg;
   assign {pad_S0_T0_out, pad_S0_T1_out, pad_S0_T2_out, pad_S0_T3_out, pad_S0_T4_out, pad_S0_T5_out, pad_S0_T6_out, pad_S0_T7_out,
           pad_S0_T8_out, pad_S0_T9_out, pad_S0_T10_out, pad_S0_T11_out, pad_S0_T12_out, pad_S0_T13_out, pad_S0_T14_out, pad_S0_T15_out} = out_bus;
   assign tdo = 1'b0;
   assign unused_jtag = ^{tdi, tms, tck, trst_n, config_data_in[31:16]};
endmodule

// File: tb/tb_cgra_top.sv
// tb_cgra_top: directed scoreboard bench for cgra_top; expected pad values come
// from a behavioural model of the config registers and ALU.
module tb_cgra_top;
   logic clk = 1'b0, rst = 1'b0;
   logic [31:0] ca = '0, cd = '0;
   logic [15:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0, o;
   logic tdi = 1'b0, tms = 1'b0, tck = 1'b0, trst_n = 1'b1, tdo;
   int n_cmp = 0, n_err = 0;
   logic [15:0] q[$];
   logic [2:0]  m_op = 3'd0;
   logic [15:0] m_cnst = 16'd2;
   logic [1:0]  m_side = 2'd2;
   logic        m_byp = 1'b0;
   always #5 clk = ~clk;
   cgra_top dut (
      .clk_in(clk), .reset_in(rst), .config_addr_in(ca), .config_data_in(cd),
      .pad_S0_T0_in(s0[15]), .pad_S0_T1_in(s0[14]), .pad_S0_T2_in(s0[13]), .pad_S0_T3_in(s0[12]),
      .pad_S0_T4_in(s0[11]), .pad_S0_T5_in(s0[10]), .pad_S0_T6_in(s0[9]), .pad_S0_T7_in(s0[8]),
      .pad_S0_T8_in(s0[7]), .pad_S0_T9_in(s0[6]), .pad_S0_T10_in(s0[5]), .pad_S0_T11_in(s0[4]),
      .pad_S0_T12_in(s0[3]), .pad_S0_T13_in(s0[2]), .pad_S0_T14_in(s0[1]), .pad_S0_T15_in(s0[0]),
      .pad_S1_T0_in(s1[15]), .pad_S1_T1_in(s1[14]), .pad_S1_T2_in(s1[13]), .pad_S1_T3_in(s1[12]),
      .pad_S1_T4_in(s1[11]), .pad_S1_T5_in(s1[10]), .pad_S1_T6_in(s1[9]), .pad_S1_T7_in(s1[8]),
      .pad_S1_T8_in(s1[7]), .pad_S1_T9_in(s1[6]), .pad_S1_T10_in(s1[5]), .pad_S1_T11_in(s1[4]),
      .pad_S1_T12_in(s1[3]), .pad_S1_T13_in(s1[2]), .pad_S1_T14_in(s1[1]), .pad_S1_T15_in(s1[0]),
      .pad_S2_T0_in(s2[15]), .pad_S2_T1_in(s2[14]), .pad_S2_T2_in(s2[13]), .pad_S2_T3_in(s2[12]),
      .pad_S2_T4_in(s2[11]), .pad_S2_T5_in(s2[10]), .pad_S2_T6_in(s2[9]), .pad_S2_T7_in(s2[8]),
      .pad_S2_T8_in(s2[7]), .pad_S2_T9_in(s2[6]), .pad_S2_T10_in(s2[5]), .pad_S2_T11_in(s2[4]),
      .pad_S2_T12_in(s2[3]), .pad_S2_T13_in(s2[2]), .pad_S2_T14_in(s2[1]), .pad_S2_T15_in(s2[0]),
      .pad_S3_T0_in(s3[15]), .pad_S3_T1_in(s3[14]), .pad_S3_T2_in(s3[13]), .pad_S3_T3_in(s3[12]),
      .pad_S3_T4_in(s3[11]), .pad_S3_T5_in(s3[10]), .pad_S3_T6_in(s3[9]), .pad_S3_T7_in(s3[8]),
      .pad_S3_T8_in(s3[7]), .pad_S3_T9_in(s3[6]), .pad_S3_T10_in(s3[5]), .pad_S3_T11_in(s3[4]),
      .pad_S3_T12_in(s3[3]), .pad_S3_T13_in(s3[2]), .pad_S3_T14_in(s3[1]), .pad_S3_T15_in(s3[0]),
      .pad_S0_T0_out(o[15]), .pad_S0_T1_out(o[14]), .pad_S0_T2_out(o[13]), .pad_S0_T3_out(o[12]),
      .pad_S0_T4_out(o[11]), .pad_S0_T5_out(o[10]), .pad_S0_T6_out(o[9]), .pad_S0_T7_out(o[8]),
      .pad_S0_T8_out(o[7]), .pad_S0_T9_out(o[6]), .pad_S0_T10_out(o[5]), .pad_S0_T11_out(o[4]),
      .pad_S0_T12_out(o[3]), .pad_S0_T13_out(o[2]), .pad_S0_T14_out(o[1]), .pad_S0_T15_out(o[0]),
      .tdi(tdi), .tms(tms), .tck(tck), .trst_n(trst_n), .tdo(tdo)
   );
   function automatic logic [15:0] f();
      logic [15:0] a;
      a = m_side == 2'd0 ? s0 : m_side == 2'd1 ? s1 : m_side == 2'd2 ? s2 : s3;
      case (m_op)
         3'd0: return a * m_cnst;
         3'd1: return a + m_cnst;
         3'd2: return a - m_cnst;
         3'd3: return a & m_cnst;
         3'd4: return a | m_cnst;
         3'd5: return a ^ m_cnst;
         3'd6: return a << m_cnst[3:0];
         default: return a;
      endcase
   endfunction
   task automatic check(input string tag);
      logic [15:0] e;
      e = q.pop_front();
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s: out=%h expected=%h", tag, o, e);
      end
      n_cmp++;
      assert (tdo === 1'b0) else begin
         n_err++;
         $error("FAIL %s_tdo: tdo=%b expected=0", tag, tdo);
      end
   endtask
   // One clock with an optional config write; registered result uses pre-write config.
   task automatic cyc(input logic [31:0] a, input logic [31:0] d, input string tag);
      logic [15:0] r;
      ca = a;
      cd = d;
      r = f();
      if (a[31:8] == 24'd0)
         case (a[7:0])
            8'h01: m_op = d[2:0];
            8'h02: m_cnst = d[15:0];
            8'h03: m_side = d[1:0];
            8'h04: m_byp = d[0];
            default: ;
         endcase
      q.push_back(m_byp ? f() : r);
      @(posedge clk);
      @(negedge clk);
      ca = '0;
      cd = '0;
      check(tag);
   endtask
   initial begin
      s2 = 16'd3;
      q.push_back(16'd0);
      #1 check("power_on");
      repeat (1000) cyc(32'd0, 32'd0, "hold6");
      s2 = 16'h8001;
      cyc(32'd0, 32'd0, "wrap_8001");
      s2 = 16'h7FFF;
      cyc(32'd0, 32'd0, "wrap_7fff");
      s2 = 16'd5;
      repeat (20) cyc(32'd0, 32'hFFFF_FFFF, "idle_addr0");
      cyc(32'h100, 32'hFFFF_FFFF, "addr_100");
      cyc(32'h103, 32'hFFFF_FFFF, "addr_103");
      cyc(32'h01, 32'd1, "wr_op");
      s2 = 16'd10;
      cyc(32'h02, 32'd5, "wr_cnst_old_cfg");
      cyc(32'd0, 32'd0, "add_15");
      s1 = 16'h1234;
      cyc(32'h03, 32'd1, "sel_side1");
      for (int i = 0; i < 8; i++) begin
         cyc(32'h01, 32'(i), "op_write");
         cyc(32'd0, 32'd0, $sformatf("op%0d", i));
      end
      s3 = 16'hA5C3;
      cyc(32'h03, 32'd3, "sel_side3");
      cyc(32'd0, 32'd0, "side3");
      s0 = 16'd7;
      s2 = 16'd3;
      cyc(32'h01, 32'd0, "op_mul");
      cyc(32'h02, 32'd2, "cnst_2");
      cyc(32'h03, 32'd0, "sel_side0");
      cyc(32'd0, 32'd0, "side0_14");
      cyc(32'h04, 32'd1, "bypass_on");
      s0 = 16'd9;
      q.push_back(f());
      #1 check("bypass_comb_18");
      cyc(32'h01, 32'd1, "bypass_op1");
      #2 rst = 1'b1;
      q.push_back(16'd0);
      #1 check("reset_async");
      ca = 32'h01;
      cd = 32'd7;
      @(posedge clk);
      @(negedge clk);
      q.push_back(16'd0);
      check("reset_hold");
      rst = 1'b0;
      ca = '0;
      cd = '0;
      m_op = 3'd0;
      m_cnst = 16'd2;
      m_side = 2'd2;
      m_byp = 1'b0;
      s2 = 16'd3;
      q.push_back(16'd0);
      #1 check("reset_release");
      cyc(32'd0, 32'd0, "post_reset_6");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
